// File: rtl/axi4lite_pkg.sv
// ============================================================================
// Module   : axi4lite_pkg
// Brief    : Response codes and channel state encodings for the AXI4-Lite
//            register slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_COLLECT = 2'd1,
        W_RESP    = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi4lite_regfile.sv
// ============================================================================
// Module   : axi4lite_regfile
// Brief    : NUM_REGS x DATA_WIDTH register array, one synchronous write port
//            and one combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_regfile #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_mem_d [NUM_REGS];

    always_comb begin
        w_mem_d = r_mem_q;
        if (i_we) begin
            w_mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    // Read is from the flops, so a same-edge write is not visible yet
    assign o_rdata = r_mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/axi4lite_reg_slave.sv
// ============================================================================
// Module   : axi4lite_reg_slave
// Brief    : AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers with
//            independent write and read channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                  A_CLK,
    input  logic                  A_RST,
    input  logic                  AW_VALID,
    output logic                  AW_READY,
    input  logic [ADDR_WIDTH-1:0] AW_ADDR,
    input  logic                  W_VALID,
    output logic                  W_READY,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    output logic                  B_VALID,
    input  logic                  B_READY,
    output logic [1:0]            B_RESP,
    input  logic                  AR_VALID,
    output logic                  AR_READY,
    input  logic [ADDR_WIDTH-1:0] AR_ADDR,
    output logic                  R_VALID,
    input  logic                  R_READY,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic [1:0]            R_RESP
);

    localparam int                    c_idx_w      = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] c_addr_limit = ADDR_WIDTH'(NUM_REGS * 4);

    // Write channel state
    wr_state_t             r_wstate_q, w_wstate_d;
    logic                  r_aw_held_q, w_aw_held_d;
    logic                  r_w_held_q, w_w_held_d;
    logic [ADDR_WIDTH-1:0] r_awaddr_q, w_awaddr_d;
    logic [DATA_WIDTH-1:0] r_wdata_q, w_wdata_d;
    logic                  r_aw_ready_q, w_aw_ready_d;
    logic                  r_w_ready_q, w_w_ready_d;
    logic                  r_b_valid_q, w_b_valid_d;
    logic [1:0]            r_b_resp_q, w_b_resp_d;

    // Read channel state
    rd_state_t             r_rstate_q, w_rstate_d;
    logic                  r_ar_ready_q, w_ar_ready_d;
    logic                  r_r_valid_q, w_r_valid_d;
    logic [DATA_WIDTH-1:0] r_r_data_q, w_r_data_d;
    logic [1:0]            r_r_resp_q, w_r_resp_d;

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic [ADDR_WIDTH-1:0] w_waddr_sel;
    logic [DATA_WIDTH-1:0] w_wdata_sel;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rf_rdata;

    assign w_aw_hs     = AW_VALID && r_aw_ready_q;
    assign w_w_hs      = W_VALID && r_w_ready_q;
    assign w_ar_hs     = AR_VALID && r_ar_ready_q;
    assign w_waddr_sel = r_aw_held_q ? r_awaddr_q : AW_ADDR;
    assign w_wdata_sel = r_w_held_q ? r_wdata_q : W_DATA;

    always_comb begin
        w_wstate_d  = r_wstate_q;
        w_aw_held_d = r_aw_held_q;
        w_w_held_d  = r_w_held_q;
        w_awaddr_d  = r_awaddr_q;
        w_wdata_d   = r_wdata_q;
        w_b_valid_d = r_b_valid_q;
        w_b_resp_d  = r_b_resp_q;
        w_we        = 1'b0;
        case (r_wstate_q)
            W_IDLE, W_COLLECT: begin
                if (w_aw_hs) begin
                    w_aw_held_d = 1'b1;
                    w_awaddr_d  = AW_ADDR;
                end
                if (w_w_hs) begin
                    w_w_held_d = 1'b1;
                    w_wdata_d  = W_DATA;
                end
                // Commit on the edge where the second half arrives
                if (w_aw_held_d && w_w_held_d) begin
                    w_we        = (w_waddr_sel < c_addr_limit);
                    w_b_valid_d = 1'b1;
                    w_b_resp_d  = w_we ? RESP_OKAY : RESP_SLVERR;
                    w_aw_held_d = 1'b0;
                    w_w_held_d  = 1'b0;
                    w_wstate_d  = W_RESP;
                end else if (w_aw_held_d || w_w_held_d) begin
                    w_wstate_d = W_COLLECT;
                end
            end
            W_RESP: begin
                if (B_READY) begin
                    w_b_valid_d = 1'b0;
                    w_wstate_d  = W_IDLE;
                end
            end
            default: w_wstate_d = W_IDLE;
        endcase
        w_aw_ready_d = (w_wstate_d != W_RESP) && !w_aw_held_d;
        w_w_ready_d  = (w_wstate_d != W_RESP) && !w_w_held_d;
    end

    always_comb begin
        w_rstate_d  = r_rstate_q;
        w_r_valid_d = r_r_valid_q;
        w_r_data_d  = r_r_data_q;
        w_r_resp_d  = r_r_resp_q;
        case (r_rstate_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_r_valid_d = 1'b1;
                    w_rstate_d  = axi4lite_pkg::R_RESP;
                    if (AR_ADDR < c_addr_limit) begin
                        w_r_data_d = w_rf_rdata;
                        w_r_resp_d = RESP_OKAY;
                    end else begin
                        w_r_data_d = '0;
                        w_r_resp_d = RESP_SLVERR;
                    end
                end
            end
            axi4lite_pkg::R_RESP: begin
                if (R_READY) begin
                    w_r_valid_d = 1'b0;
                    w_rstate_d  = R_IDLE;
                end
            end
            default: w_rstate_d = R_IDLE;
        endcase
        w_ar_ready_d = (w_rstate_d == R_IDLE);
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            r_wstate_q   <= W_IDLE;
            r_aw_held_q  <= 1'b0;
            r_w_held_q   <= 1'b0;
            r_awaddr_q   <= '0;
            r_wdata_q    <= '0;
            r_aw_ready_q <= 1'b0;
            r_w_ready_q  <= 1'b0;
            r_b_valid_q  <= 1'b0;
            r_b_resp_q   <= RESP_OKAY;
            r_rstate_q   <= R_IDLE;
            r_ar_ready_q <= 1'b0;
            r_r_valid_q  <= 1'b0;
            r_r_data_q   <= '0;
            r_r_resp_q   <= RESP_OKAY;
        end else begin
            r_wstate_q   <= w_wstate_d;
            r_aw_held_q  <= w_aw_held_d;
            r_w_held_q   <= w_w_held_d;
            r_awaddr_q   <= w_awaddr_d;
            r_wdata_q    <= w_wdata_d;
            r_aw_ready_q <= w_aw_ready_d;
            r_w_ready_q  <= w_w_ready_d;
            r_b_valid_q  <= w_b_valid_d;
            r_b_resp_q   <= w_b_resp_d;
            r_rstate_q   <= w_rstate_d;
            r_ar_ready_q <= w_ar_ready_d;
            r_r_valid_q  <= w_r_valid_d;
            r_r_data_q   <= w_r_data_d;
            r_r_resp_q   <= w_r_resp_d;
        end
    end

    axi4lite_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (c_idx_w)
    ) u_regfile (
        .clk     (A_CLK),
        .rst     (A_RST),
        .i_we    (w_we),
        .i_waddr (w_waddr_sel[c_idx_w+1:2]),
        .i_wdata (w_wdata_sel),
        .i_raddr (AR_ADDR[c_idx_w+1:2]),
        .o_rdata (w_rf_rdata)
    );

    assign AW_READY = r_aw_ready_q;
    assign W_READY  = r_w_ready_q;
    assign B_VALID  = r_b_valid_q;
    assign B_RESP   = r_b_resp_q;
    assign AR_READY = r_ar_ready_q;
    assign R_VALID  = r_r_valid_q;
    assign R_DATA   = r_r_data_q;
    assign R_RESP   = r_r_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_reg_slave.sv
// ============================================================================
// Module   : tb_axi4lite_reg_slave
// Brief    : Directed vector bench for axi4lite_reg_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4lite_reg_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 1'b0, aw_ready;
    logic [31:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [31:0] w_data = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [31:0] ar_addr = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4lite_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) dut (
        .A_CLK    (clk),
        .A_RST    (rst),
        .AW_VALID (aw_valid),
        .AW_READY (aw_ready),
        .AW_ADDR  (aw_addr),
        .W_VALID  (w_valid),
        .W_READY  (w_ready),
        .W_DATA   (w_data),
        .B_VALID  (b_valid),
        .B_READY  (b_ready),
        .B_RESP   (b_resp),
        .AR_VALID (ar_valid),
        .AR_READY (ar_ready),
        .AR_ADDR  (ar_addr),
        .R_VALID  (r_valid),
        .R_READY  (r_ready),
        .R_DATA   (r_data),
        .R_RESP   (r_resp)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            output logic [1:0] resp);
        int  cnt;
        logic af, wf;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = addr;
        w_valid  = 1'b1; w_data  = data;
        cnt = 0;
        while ((aw_valid || w_valid) && cnt < 20) begin
            af = aw_ready; wf = w_ready;
            @(negedge clk);
            if (af) aw_valid = 1'b0;
            if (wf) w_valid  = 1'b0;
            cnt++;
        end
        if (cnt >= 20) begin
            timeout("write addr/data");
            aw_valid = 1'b0; w_valid = 1'b0;
        end
        b_ready = 1'b1;
        cnt = 0;
        while (!b_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) timeout("write resp");
        resp = b_resp;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [1:0] resp,
                           output logic [31:0] data);
        int cnt;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = addr;
        cnt = 0;
        while (!ar_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) timeout("read addr");
        @(negedge clk);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        cnt = 0;
        while (!r_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) timeout("read data");
        resp = r_resp;
        data = r_data;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;

        vecs[0]  = '{1'b0, 32'h04, 32'h0,        2'b00, 32'h00000000};
        vecs[1]  = '{1'b1, 32'h04, 32'h12345678, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,        2'b00, 32'h12345678};
        vecs[3]  = '{1'b1, 32'h10, 32'hCAFEF00D, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h13, 32'h0,        2'b00, 32'hCAFEF00D};
        vecs[5]  = '{1'b1, 32'h3C, 32'hFFFFFFFF, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 32'h3C, 32'h0,        2'b00, 32'hFFFFFFFF};
        vecs[7]  = '{1'b1, 32'h40, 32'h11111111, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 32'h40, 32'h0,        2'b10, 32'h00000000};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,        2'b00, 32'h00000000};
        vecs[10] = '{1'b1, 32'h80000004, 32'h22222222, 2'b10, 32'h0};
        vecs[11] = '{1'b0, 32'h04, 32'h0,        2'b00, 32'h12345678};
        vecs[12] = '{1'b0, 32'h7FFFFFFC, 32'h0,  2'b10, 32'h00000000};
        vecs[13] = '{1'b0, 32'h38, 32'h0,        2'b00, 32'h00000000};

        // Reset held three cycles
        repeat (3) @(negedge clk);
        check("rst aw_ready", {31'b0, aw_ready}, 32'd0);
        check("rst b_valid",  {31'b0, b_valid},  32'd0);
        check("rst r_valid",  {31'b0, r_valid},  32'd0);
        check("rst r_data",   r_data,            32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst ready", {29'b0, aw_ready, w_ready, ar_ready}, 32'h7);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, resp);
                check($sformatf("vec%0d b_resp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            end else begin
                do_read(vecs[i].addr, resp, data);
                check($sformatf("vec%0d r_resp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
                check($sformatf("vec%0d r_data", i), data, vecs[i].exp_data);
            end
        end

        // W leads AW by three cycles
        @(negedge clk);
        w_valid = 1'b1; w_data = 32'hDEADBEEF;
        @(negedge clk);
        w_valid = 1'b0;
        check("w-first w_ready low", {31'b0, w_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("w-first no b yet", {31'b0, b_valid}, 32'd0);
        aw_valid = 1'b1; aw_addr = 32'h08;
        @(negedge clk);
        aw_valid = 1'b0;
        check("w-first b_valid", {31'b0, b_valid}, 32'd1);
        check("w-first b_resp", {30'b0, b_resp}, 32'd0);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("w-first b cleared", {31'b0, b_valid}, 32'd0);
        check("w-first ready back", {30'b0, aw_ready, w_ready}, 32'h3);
        do_read(32'h08, resp, data);
        check("w-first rd 0x08", data, 32'hDEADBEEF);
        do_read(32'h04, resp, data);
        check("w-first rd 0x04", data, 32'h12345678);

        // Response backpressure on both channels
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = 32'h14; w_valid = 1'b1; w_data = 32'h5555AAAA;
        ar_valid = 1'b1; ar_addr = 32'h04;
        @(negedge clk);
        aw_addr = 32'h18; w_data = 32'h77777777; ar_addr = 32'h08;
        for (int k = 0; k < 5; k++) begin
            check("bp b_valid", {31'b0, b_valid}, 32'd1);
            check("bp b_resp", {30'b0, b_resp}, 32'd0);
            check("bp r_valid", {31'b0, r_valid}, 32'd1);
            check("bp r_data", r_data, 32'h12345678);
            check("bp readies low", {29'b0, aw_ready, w_ready, ar_ready}, 32'd0);
            @(negedge clk);
        end
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        b_ready = 1'b1; r_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0; r_ready = 1'b0;
        check("bp valids cleared", {30'b0, b_valid, r_valid}, 32'd0);
        check("bp readies back", {29'b0, aw_ready, w_ready, ar_ready}, 32'h7);
        do_read(32'h14, resp, data);
        check("bp rd 0x14", data, 32'h5555AAAA);
        do_read(32'h18, resp, data);
        check("bp rd 0x18", data, 32'h00000000);

        // Read handshake on the write-commit edge sees the old value
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = 32'h0C; w_valid = 1'b1; w_data = 32'hA5A5A5A5;
        ar_valid = 1'b1; ar_addr = 32'h0C;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        check("conc b_valid", {31'b0, b_valid}, 32'd1);
        check("conc r_valid", {31'b0, r_valid}, 32'd1);
        check("conc r_data old", r_data, 32'h00000000);
        b_ready = 1'b1; r_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0; r_ready = 1'b0;
        do_read(32'h0C, resp, data);
        check("conc rd new", data, 32'hA5A5A5A5);

        // Reset aborts a half-collected write
        @(negedge clk);
        w_valid = 1'b1; w_data = 32'h99999999;
        @(negedge clk);
        w_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = 32'h20;
        @(negedge clk);
        aw_valid = 1'b0;
        check("abort no b", {31'b0, b_valid}, 32'd0);
        check("abort w_ready", {31'b0, w_ready}, 32'd1);
        do_read(32'h0C, resp, data);
        check("abort regs cleared", data, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
AXI4-Lite slave exposing a bank of 32-bit read/write registers to a single AXI4-Lite master, such as a verification IP master or interconnect port. Write and read channels operate independently. Each accepted write updates one register, and each accepted read returns the register contents. Minimal signal set: no WSTRB, no PROT.

Parameters:
ADDR_WIDTH, 32, width of AW_ADDR/AR_ADDR
DATA_WIDTH, 32, register and data bus width (only 32 supported)
NUM_REGS, 16, number of registers; occupy byte offsets 0x00..(NUM_REGS*4-4)

Ports:
A_CLK  in  1  clock, all logic on rising edge
A_RST  in  1  synchronous active-high reset
AW_VALID  in  1  write address valid
AW_READY  out  1  write address ready
AW_ADDR  in  ADDR_WIDTH  write byte address
W_VALID  in  1  write data valid
W_READY  out  1  write data ready
W_DATA  in  DATA_WIDTH  write data
B_VALID  out  1  write response valid
B_READY  in  1  write response ready
B_RESP  out  2  write response
AR_VALID  in  1  read address valid
AR_READY  out  1  read address ready
AR_ADDR  in  ADDR_WIDTH  read byte address
R_VALID  out  1  read data valid
R_READY  in  1  read data ready
R_DATA  out  DATA_WIDTH  read data
R_RESP  out  2  read response

Behaviour:
- Reset (A_RST=1 at an edge):
  - All registers = 0.
  - AW_READY, W_READY, AR_READY, B_VALID, R_VALID = 0.
  - B_RESP, R_RESP = 2'b00; R_DATA = 0.
  - Pending latched address/data are discarded.
  - Readies rise on the first edge after reset deasserts.
- Decode:
  - Register index = addr[$clog2(NUM_REGS)+1:2].
  - addr[1:0] is ignored.
  - Addresses >= NUM_REGS*4 are out of range.
- Write channel: states IDLE, COLLECT, RESP.
  - AW and W handshakes (VALID&&READY at an edge) may occur in the same cycle or in either order.
  - AW_READY drops after AW is captured; W_READY drops after W is captured.
  - At the edge where both are held:
    - In range: the register is written, B_RESP=OKAY (00).
    - Out of range: no write, B_RESP=SLVERR (10).
    - B_VALID=1 from the next cycle.
  - B_VALID and B_RESP are held stable until B_READY. On the B handshake edge, B_VALID=0 and AW_READY/W_READY return to 1.
  - Only one write is outstanding at a time.
- Read channel: states IDLE, RESP.
  - AR_READY=1 in IDLE.
  - On the AR handshake edge:
    - In range: R_DATA = register value as of that edge (pre-write value if a write commits on the same edge), R_RESP=OKAY.
    - Out of range: R_DATA=0, R_RESP=SLVERR.
    - R_VALID=1 and AR_READY=0 from the next cycle.
  - R_DATA/R_RESP are held stable until the R handshake; then R_VALID=0 and AR_READY=1.
- Read and write channels are fully concurrent and share only the register array.
- Minimum latency: write handshake to B_VALID = 1 cycle; AR handshake to R_VALID = 1 cycle.
- Back-to-back transactions:
  - A new AW/W is accepted one cycle after the B handshake.
  - A new AR is accepted one cycle after the R handshake.
- Reset mid-transaction aborts it; no response is issued.

Decomposition:
- Package axi4lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write FSM enum (W_IDLE, W_COLLECT, W_RESP), read FSM enum (R_IDLE, R_RESP).
- One natural sub-module, axi4lite_regfile: NUM_REGS x 32 array with one write port and one combinational read port.

Test Plan:
- Reset: hold A_RST 3 cycles, release -> all VALIDs 0, readies 1 one cycle later; read 0x04 -> R_DATA=0x00000000, R_RESP=00.
- Write 0x04=0x12345678 with AW/W simultaneous, then read 0x04 -> B_RESP=00, R_DATA=0x12345678, R_RESP=00.
- W before AW by 3 cycles, write 0x08=0xDEADBEEF -> single B response after AW; read 0x08 returns 0xDEADBEEF; 0x04 unchanged.
- B_READY and R_READY held low 5 cycles -> B_VALID/R_VALID and their payloads stay stable; no new AW/AR accepted meanwhile.
- Write/read address 0x40 (NUM_REGS=16) -> B_RESP=10, R_RESP=10, R_DATA=0; no register modified.
- Concurrent write 0x0C=0xA5A5A5A5 and read 0x0C with the AR handshake on the write-commit edge -> read returns old value 0; a following read returns 0xA5A5A5A5.
